act_requant: RTL

ACT_REQUANT -- requirements
Module: act_requant

---
 rtl/act_requant.sv | 120 ++++++++++++
 1 files changed

// File: rtl/act_requant.sv
// act_requant - per-channel requantization (optional ReLU, scale, round, shift, saturate) of a 32x12 conv frame
module act_requant #(
  parameter int W     = 16,
  parameter int SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [32*12*W-1:0]  d,
  input  logic                relu_en,
  input  logic [7:0]          scale,
  input  logic                out_ack,
  output logic                busy,
  output logic                out_valid,
  output logic                sat,
  output logic [32*12*W-1:0]  q
);

  localparam int PW = W + 10;

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t               state, state_nxt;
  logic [4:0]           ch;
  logic [32*12*W-1:0]   d_reg;
  logic [32*12*W-1:0]   q_reg;
  logic                 relu_reg;
  logic [7:0]           scale_reg;
  logic                 sat_reg;
  logic [12*W-1:0]      d_ch;
  logic [12*W-1:0]      res;
  logic [11:0]          clip;
  logic [W:0]           lane_r [12];

  // Returns {clipped, saturated result} for one element.
  function automatic logic [W:0] requant(input logic signed [W-1:0] x,
                                         input logic relu,
                                         input logic [7:0] s);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] se;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] y;
    logic signed [PW-1:0] maxv;
    logic signed [PW-1:0] minv;
    logic [W:0]           r;
    xe   = (relu && x < 0) ? '0 : {{10{x[W-1]}}, x};
    se   = {{(PW-8){1'b0}}, s};
    rnd  = '0;
    rnd[SHIFT-1] = 1'b1;
    maxv = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    minv = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
    y    = (xe * se + rnd) >>> SHIFT;
    if (y > maxv)      r = {1'b1, maxv[W-1:0]};
    else if (y < minv) r = {1'b1, minv[W-1:0]};
    else               r = {1'b0, y[W-1:0]};
    return r;
  endfunction

  always_comb begin
    d_ch = '0;
    for (int c = 0; c < 32; c++) begin
      if (ch == 5'(c)) d_ch = d_reg[c*12*W +: 12*W];
    end
  end

  for (genvar e = 0; e < 12; e++) begin : g_lane
    assign lane_r[e]         = requant(d_ch[e*W +: W], relu_reg, scale_reg);
    assign res[e*W +: W]     = lane_r[e][W-1:0];
    assign clip[e]           = lane_r[e][W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PROC;
      PROC:    if (ch == 5'd31) state_nxt = DONE;
      DONE:    if (out_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      d_reg     <= '0;
      q_reg     <= '0;
      relu_reg  <= 1'b0;
      scale_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg     <= d;
            relu_reg  <= relu_en;
            scale_reg <= scale;
            sat_reg   <= 1'b0;
            ch        <= '0;
          end
        end
        PROC: begin
          for (int c = 0; c < 32; c++) begin
            if (ch == 5'(c)) q_reg[c*12*W +: 12*W] <= res;
          end
          sat_reg <= sat_reg | (|clip);
          ch      <= ch + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign sat       = sat_reg;
  assign q         = q_reg;

endmodule
